// File: rtl/seg_scan_ctrl_if.sv
// Display-scan bundle between the scan sequencer and its upstream/downstream users.
// The slave modport is the sequencer itself; the master side drives the enables.
interface seg_scan_ctrl_if;
    logic       scan_en;
    logic [7:0] digit_en;
    logic [2:0] sel;
    logic [7:0] an;
    logic       digit_tick;
    logic       frame_done;

    modport slave (
        input  scan_en,
        input  digit_en,
        output sel,
        output an,
        output digit_tick,
        output frame_done
    );

    modport master (
        output scan_en,
        output digit_en,
        input  sel,
        input  an,
        input  digit_tick,
        input  frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan sequencer: blank gap, dwell, advance, repeat.
// Define SCAN_MASK_EN to skip digits whose digit_en bit is clear.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 17
) (
    input  logic           clk,
    input  logic           reset_n,
    seg_scan_ctrl_if.slave bus
);

    localparam logic [0:0]       ST_BLANK   = 1'b0;
    localparam logic [0:0]       ST_SHOW    = 1'b1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_sel;
    logic [7:0]       r_an;
    logic             r_digitTick;
    logic             r_frameDone;

    logic [2:0]       w_nextSel;
    logic             w_digitOn;
    logic             w_maskEmpty;
    logic [7:0]       w_litAn;

`ifdef SCAN_MASK_EN
    logic [2:0] w_above;
    logic [2:0] w_lowest;
    logic       w_hasAbove;

    // Descending search leaves the lowest matching index in each candidate.
    always_comb begin
        w_above    = '0;
        w_lowest   = r_sel;
        w_hasAbove = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.digit_en[i]) begin
                w_lowest = 3'(i);
                if (3'(i) > r_sel) begin
                    w_above    = 3'(i);
                    w_hasAbove = 1'b1;
                end
            end
        end
    end

    assign w_nextSel   = w_hasAbove ? w_above : w_lowest;
    assign w_digitOn   = bus.digit_en[r_sel];
    assign w_maskEmpty = (bus.digit_en == 8'h00);
`else
    assign w_nextSel   = r_sel + 3'd1;
    assign w_digitOn   = 1'b1;
    assign w_maskEmpty = 1'b0;
`endif

    assign w_litAn = w_digitOn ? ~(8'h01 << r_sel) : 8'hFF;

    // sel only moves on the dwell-to-blank edge, so the mux never switches under a lit anode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_BLANK;
            r_cnt       <= '0;
            r_sel       <= 3'd0;
            r_an        <= 8'hFF;
            r_digitTick <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_digitTick <= 1'b0;
            r_frameDone <= 1'b0;
            if (!bus.scan_en) begin
                r_an <= 8'hFF;
            end else if (w_maskEmpty) begin
                r_state <= ST_BLANK;
                r_cnt   <= '0;
                r_an    <= 8'hFF;
            end else if (r_state == ST_BLANK) begin
                if (r_cnt == BLANK_LAST) begin
                    r_cnt   <= '0;
                    r_state <= ST_SHOW;
                    r_an    <= w_litAn;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_an  <= 8'hFF;
                end
            end else begin
                if (r_cnt == SHOW_LAST) begin
                    r_cnt       <= '0;
                    r_state     <= ST_BLANK;
                    r_an        <= 8'hFF;
                    r_sel       <= w_nextSel;
                    r_digitTick <= 1'b1;
                    r_frameDone <= (w_nextSel <= r_sel);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_an  <= w_litAn;
                end
            end
        end
    end

    assign bus.sel        = r_sel;
    assign bus.an         = r_an;
    assign bus.digit_tick = r_digitTick;
    assign bus.frame_done = r_frameDone;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Sequencer for the 8-digit seven-segment display path. Time-multiplexes the eight digits, one at a time and cyclically.
- Drives the 3-bit nibble-select (`sel`) of the downstream 8:1 address/data nibble mux.
- Drives the active-low anode enables, with a blanking gap between digits to suppress ghosting.
- Emits per-digit and per-frame strobes for upstream logic such as RAM address stepping.

Parameters:
- REFRESH_DIV, 100000, clocks each digit is lit (dwell). Must be >= 2.
- BLANK_CYCLES, 16, clocks all anodes are off before each digit is lit. Must be >= 1.
- CNT_W, 17, width of the internal dwell/blank counter. Must hold max(REFRESH_DIV, BLANK_CYCLES) - 1.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- scan_en, input, 1, 1 = scan runs; 0 = freeze scan and blank all anodes.
- digit_en, input, 8, per-digit enable mask; bit i enables digit i. Used only with SCAN_MASK_EN.
- sel, output, 3, nibble select to the display mux (0..7 = digit index).
- an, output, 8, anode enables, active-low, at most one bit low.
- digit_tick, output, 1, one-cycle pulse when `sel` advances.
- frame_done, output, 1, one-cycle pulse when `sel` wraps back to the first digit.

Behaviour:
- Single clock `clk`; asynchronous active-low reset `reset_n`. All outputs are registered.
- Reset values:
  - `sel` = 0, `an` = 8'hFF, `digit_tick` = 0, `frame_done` = 0.
  - FSM state = BLANK, counter `cnt` = 0.
  - Reset takes effect immediately on `reset_n` falling, including mid-dwell.
- FSM states: BLANK and SHOW.
- BLANK:
  - `an` = 8'hFF.
  - `cnt` increments each enabled clock.
  - When `cnt` == BLANK_CYCLES-1: `cnt` <= 0, state <= SHOW, `an` <= ~(8'h01 << `sel`) on the same edge.
- SHOW:
  - `an` holds a single low bit at position `sel`.
  - When `cnt` == REFRESH_DIV-1:
    - `cnt` <= 0, state <= BLANK, `an` <= 8'hFF.
    - `sel` <= next digit index.
    - `digit_tick` <= 1 for one cycle.
- Per-digit period = BLANK_CYCLES + REFRESH_DIV clocks.
- Latency: first digit lit BLANK_CYCLES clocks after reset release with `scan_en` = 1.
- Without the mask, next digit = (`sel`+1) mod 8 (3-bit wrap).
- `frame_done` pulses on the same edge as `digit_tick` when the new `sel` is numerically <= the old `sel`; without the mask this is exactly the 7->0 transition.
- `scan_en` = 0:
  - `an` <= 8'hFF on the next edge.
  - `cnt`, state and `sel` are held; strobes are 0.
  - On re-enable, counting resumes from the held `cnt`, and `an` re-asserts for the held digit if the state is SHOW.
  - `scan_en` low on the terminal-count cycle cancels the advance.
- Strobes are never high for more than one consecutive cycle.
- `sel` changes only while `an` = 8'hFF, so there is no glitch on the displayed nibble.

Optional Feature:
- Macro: SCAN_MASK_EN.
- When defined:
  - Next digit = the lowest enabled index above `sel`, else the lowest enabled index overall (cyclic skip of masked digits).
  - If the current digit's `digit_en` bit is 0 during SHOW, `an` <= 8'hFF on the next edge and the dwell completes normally.
  - If `digit_en` == 0: FSM stays in BLANK, `cnt` held at 0, `an` = 8'hFF, `sel` held, no strobes.
  - A single enabled digit: `sel` never changes value, yet `digit_tick` and `frame_done` pulse once per period.
- When undefined: `digit_en` is ignored and all 8 digits are scanned.

Test Plan:
Unless stated otherwise, parameters are REFRESH_DIV=4, BLANK_CYCLES=2.
1. Reset: assert `reset_n`=0 mid-SHOW between clock edges -> `an`=8'hFF and `sel`=0 immediately (no clock); strobes 0; held while low.
2. Release reset, `scan_en`=1 -> `an`=FF for 2 clocks, 8'hFE for 4 clocks, FF for 2 clocks, then 8'hFD with `sel`=1; `digit_tick` high exactly one cycle at the 0->1 advance.
3. Free-run 200 clocks:
   - `sel` sequence 0..7,0 with 6-clock spacing.
   - `frame_done` pulses every 48 clocks, coincident with 7->0.
   - `an` never has more than one low bit.
   - `sel` never changes while `an` != FF.
4. Drop `scan_en` for 10 clocks after 1 SHOW clock on digit 3 -> `an`=FF next edge and `sel` stays 3; on re-enable, 8'hF7 is shown for the remaining 3 clocks.
5. SCAN_MASK_EN, `digit_en`=8'b1000_0101:
   - `sel` sequence 0,2,7,0,… and `frame_done` only at 7->0.
   - Then set `digit_en`=8'h00 -> `an` stays FF and no strobes; restore 8'h01 -> `sel` stays 0 and `frame_done` pulses every 6 clocks.
6. Macro undefined, `digit_en`=8'h00 -> full 0..7 scan identical to scenario 3.
